dbus_arbiter: RTL

Round-robin arbiter and transaction sequencer sharing the single data-bus slave port between several masters: CPU memory stage, DMA engine, debug port. Captures the winning master's command, drives the slave side, waits out slave wait-states and read latency, and returns completion per master. Its per-master `o_Gnt`/`o_WaitReq` feed the CPU hazard unit's bus-grant and wait-request stall inputs.

---
 rtl/dbus_arbiter.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/dbus_arbiter.sv
// dbus_arbiter: round-robin arbiter and single-outstanding transaction
// sequencer sharing one data-bus slave port between several masters.
// Optional feature macro: DBUS_ARB_TIMEOUT_EN -- aborts a transaction that
// spends TIMEOUT_CYCLES cycles in XFER+RESP, completing it with o_Err=1.
module dbus_arbiter #(
  parameter int NUM_MASTERS    = 3,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                          i_Clk,
  input  logic                          i_Rst_n,
  input  logic [NUM_MASTERS-1:0]        i_Req,
  input  logic [NUM_MASTERS-1:0]        i_We,
  input  logic [NUM_MASTERS*ADDR_W-1:0] i_Addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] i_WData,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] i_ByteEn,
  output logic [NUM_MASTERS-1:0]        o_Gnt,
  output logic [NUM_MASTERS-1:0]        o_WaitReq,
  output logic [NUM_MASTERS-1:0]        o_Ack,
  output logic [DATA_W-1:0]             o_RData,
  output logic                          o_Err,
  output logic                          o_Busy,
  output logic                          o_SReq,
  output logic                          o_SWe,
  output logic [ADDR_W-1:0]             o_SAddr,
  output logic [DATA_W-1:0]             o_SWData,
  output logic [DATA_W/8-1:0]           o_SByteEn,
  input  logic                          i_SWaitReq,
  input  logic [DATA_W-1:0]             i_SRData,
  input  logic                          i_SRDataValid
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [IDX_W-1:0]       last_r;
  logic [IDX_W-1:0]       win_idx_s;
  logic                   win_found_s;
  int                     cand_s;
  logic                   abort_s;
  logic                   timeout_hit_s;
  logic                   enter_done_s;

  logic [NUM_MASTERS-1:0] gnt_r;
  logic [NUM_MASTERS-1:0] ack_r;
  logic [DATA_W-1:0]      rdata_r;
  logic                   err_r;
  logic                   busy_r;
  logic                   sreq_r;
  logic                   swe_r;
  logic [ADDR_W-1:0]      saddr_r;
  logic [DATA_W-1:0]      swdata_r;
  logic [BE_W-1:0]        sbyteen_r;

`ifdef DBUS_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_r;

  // Cycle counter for the current transaction; restarts when a grant is made.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      tmo_cnt_r <= '0;
    end else if (state_r == ST_IDLE) begin
      tmo_cnt_r <= '0;
    end else if ((state_r == ST_XFER) || (state_r == ST_RESP)) begin
      tmo_cnt_r <= tmo_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end

  // The cycle that would be the TIMEOUT_CYCLES-th one in XFER+RESP aborts.
  assign timeout_hit_s = (tmo_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  // No abort path: the parameter only matters when the counter is built.
  assign timeout_hit_s = (TIMEOUT_CYCLES < 32'sd0);
`endif

  // Round-robin pick: first requester at or after last-granted + 1.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    cand_s      = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      cand_s = (int'(last_r) + 1 + i) % NUM_MASTERS;
      if (!win_found_s && i_Req[cand_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = IDX_W'(cand_s);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Next-state logic; completion beats the timeout in the same cycle.
  always_comb begin
    state_nxt_s = state_r;
    abort_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (win_found_s) state_nxt_s = ST_XFER;
        else             state_nxt_s = ST_IDLE;
      end
      ST_XFER: begin
        if (!i_SWaitReq && swe_r) begin
          state_nxt_s = ST_DONE;
        end else if (timeout_hit_s) begin
          state_nxt_s = ST_DONE;
          abort_s     = 1'b1;
        end else if (!i_SWaitReq) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_XFER;
        end
      end
      ST_RESP: begin
        if (i_SRDataValid) begin
          state_nxt_s = ST_DONE;
        end else if (timeout_hit_s) begin
          state_nxt_s = ST_DONE;
          abort_s     = 1'b1;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  assign enter_done_s = (state_r != ST_DONE) && (state_nxt_s == ST_DONE);

  // State register.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) state_r <= ST_IDLE;
    else          state_r <= state_nxt_s;
  end

  // Grant, round-robin pointer and command capture at the moment of grant.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      gnt_r     <= '0;
      last_r    <= IDX_W'(NUM_MASTERS - 1);
      swe_r     <= 1'b0;
      saddr_r   <= '0;
      swdata_r  <= '0;
      sbyteen_r <= '0;
    end else if ((state_r == ST_IDLE) && win_found_s) begin
      gnt_r     <= {{(NUM_MASTERS-1){1'b0}}, 1'b1} << win_idx_s;
      last_r    <= win_idx_s;
      swe_r     <= i_We[win_idx_s];
      saddr_r   <= i_Addr[win_idx_s*ADDR_W +: ADDR_W];
      swdata_r  <= i_WData[win_idx_s*DATA_W +: DATA_W];
      sbyteen_r <= i_ByteEn[win_idx_s*BE_W +: BE_W];
    end else if (state_r == ST_DONE) begin
      gnt_r     <= '0;
    end else begin
      gnt_r     <= gnt_r;
    end
  end

  // Slave request is raised with the grant and dropped once XFER is left.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sreq_r <= 1'b0;
    end else if ((state_r == ST_IDLE) && win_found_s) begin
      sreq_r <= 1'b1;
    end else if ((state_r == ST_XFER) && (state_nxt_s != ST_XFER)) begin
      sreq_r <= 1'b0;
    end else begin
      sreq_r <= sreq_r;
    end
  end

  // Completion pulse, error flag and busy, all timed from the next state.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      ack_r  <= '0;
      err_r  <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      ack_r  <= enter_done_s ? gnt_r : '0;
      err_r  <= enter_done_s & abort_s;
      busy_r <= (state_nxt_s != ST_IDLE);
    end
  end

  // Read data: captured on valid in RESP, zeroed on abort, else held.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rdata_r <= '0;
    end else if (abort_s) begin
      rdata_r <= '0;
    end else if ((state_r == ST_RESP) && i_SRDataValid) begin
      rdata_r <= i_SRData;
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign o_Gnt     = gnt_r;
  assign o_Ack     = ack_r;
  assign o_WaitReq = i_Req & ~ack_r;
  assign o_RData   = rdata_r;
  assign o_Err     = err_r;
  assign o_Busy    = busy_r;
  assign o_SReq    = sreq_r;
  assign o_SWe     = swe_r;
  assign o_SAddr   = saddr_r;
  assign o_SWData  = swdata_r;
  assign o_SByteEn = sbyteen_r;

endmodule
